// File: rtl/sram_pkg.sv
// Shared types and constants for the iceFUN external SRAM/PSRAM controller.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 22;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_BE_W   = 2;
  localparam int unsigned TIMER_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4
  } sram_state_e;

  // Pin values while the chip is deselected
  localparam logic PIN_CE_N_IDLE = 1'b1;
  localparam logic PIN_CE2_RST   = 1'b0;
  localparam logic PIN_WE_N_IDLE = 1'b1;
  localparam logic PIN_OE_N_IDLE = 1'b1;
  localparam logic PIN_BE_N_IDLE = 1'b1;

  // Latched request payload
  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_BE_W-1:0]   be;
  } sram_req_t;

  // Zero the byte lanes whose enable is low
  function automatic logic [SRAM_DATA_W-1:0] lane_mask(
    input logic [SRAM_DATA_W-1:0] data,
    input logic [SRAM_BE_W-1:0]   be
  );
    lane_mask = {(be[1] ? data[15:8] : 8'h00), (be[0] ? data[7:0] : 8'h00)};
  endfunction

endpackage

// File: rtl/sram_ctrl_timer.sv
// Loadable 4-bit down-counter; done is high during the last counted cycle.
module sram_ctrl_timer
  import sram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               en,
  output logic               done
);

  logic [TIMER_W-1:0] cnt;

  // A load of 0 or 1 is already on its final cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      done <= (load_val <= TIMER_W'(1));
    end else if (en && !done) begin
      cnt  <= cnt - TIMER_W'(1);
      done <= (cnt == TIMER_W'(2));
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready to asynchronous 16-bit SRAM/PSRAM pin sequencer.
// Optional: SRAM_CTRL_CE2_PD_EN drops ce2 outside the access window (power-down).
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W  = SRAM_ADDR_W,
  parameter int unsigned DATA_W  = SRAM_DATA_W,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              sram_ce_n,
  output logic              sram_ce2,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_i
);

`ifdef SRAM_CTRL_CE2_PD_EN
  localparam logic CE2_IDLE = 1'b0;
`else
  localparam logic CE2_IDLE = 1'b1;
`endif

  sram_state_e       state;
  sram_req_t         req_q;
  logic              timer_done;
  logic              timer_load;
  logic              timer_en;
  logic [TIMER_W-1:0] timer_val;

  assign timer_load = (state == ST_SETUP);
  assign timer_en   = (state == ST_ACCESS);
  assign timer_val  = req_q.we ? TIMER_W'(WR_WAIT) : TIMER_W'(RD_WAIT);

  sram_ctrl_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  // Pins are assigned for the state being entered, so they change only on clk
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      sram_ce_n  <= PIN_CE_N_IDLE;
      sram_ce2   <= PIN_CE2_RST;
      sram_we_n  <= PIN_WE_N_IDLE;
      sram_oe_n  <= PIN_OE_N_IDLE;
      sram_lb_n  <= PIN_BE_N_IDLE;
      sram_ub_n  <= PIN_BE_N_IDLE;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          sram_ce2 <= CE2_IDLE;
          if (req_valid && req_ready) begin
            state      <= ST_SETUP;
            req_ready  <= 1'b0;
            req_q.we   <= req_we;
            req_q.addr <= SRAM_ADDR_W'(req_addr);
            req_q.wdata <= SRAM_DATA_W'(req_wdata);
            req_q.be   <= req_be;
            sram_ce_n  <= 1'b0;
            sram_ce2   <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_lb_n  <= ~req_be[0];
            sram_ub_n  <= ~req_be[1];
            sram_addr  <= req_addr;
            sram_dq_o  <= req_we ? req_wdata : '0;
            sram_dq_oe <= req_we;
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          state <= ST_ACCESS;
          if (req_q.we) sram_we_n <= 1'b0;
          else          sram_oe_n <= 1'b0;
        end

        ST_ACCESS: begin
          if (timer_done) begin
            if (req_q.we) begin
              state     <= ST_HOLD;
              sram_we_n <= 1'b1;
            end else begin
              state     <= ST_RECOVER;
              rsp_valid <= 1'b1;
              rsp_rdata <= DATA_W'(lane_mask(SRAM_DATA_W'(sram_dq_i), req_q.be));
              sram_oe_n <= 1'b1;
              sram_ce_n <= 1'b1;
              sram_ce2  <= CE2_IDLE;
              sram_lb_n <= 1'b1;
              sram_ub_n <= 1'b1;
            end
          end
        end

        // Data stays driven one cycle past the we_n rising edge
        ST_HOLD: begin
          state      <= ST_RECOVER;
          sram_ce_n  <= 1'b1;
          sram_ce2   <= CE2_IDLE;
          sram_dq_oe <= 1'b0;
          sram_lb_n  <= 1'b1;
          sram_ub_n  <= 1'b1;
        end

        ST_RECOVER: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end

        default: begin
          state      <= ST_IDLE;
          req_ready  <= 1'b0;
          sram_ce_n  <= PIN_CE_N_IDLE;
          sram_we_n  <= PIN_WE_N_IDLE;
          sram_oe_n  <= PIN_OE_N_IDLE;
          sram_lb_n  <= PIN_BE_N_IDLE;
          sram_ub_n  <= PIN_BE_N_IDLE;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a small behavioural SRAM attached.
module tb_sram_ctrl;

  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [21:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        sram_ce_n, sram_ce2, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n;
  logic [21:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_i;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] mem [0:63];

  sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_ce_n(sram_ce_n), .sram_ce2(sram_ce2), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
    .sram_dq_i(sram_dq_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: contents restored on rst, byte writes while we_n low
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(i * 16'h0101);
      mem[3]  <= 16'h1234;
      mem[16] <= 16'hFFFF;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_lb_n) mem[sram_addr[5:0]][7:0]  <= sram_dq_o[7:0];
      if (!sram_ub_n) mem[sram_addr[5:0]][15:8] <= sram_dq_o[15:8];
    end
  end
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_rdata), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
        chk("rsp_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Pin-timing monitor
  int   oe_run = 0, we_run = 0, we_rise = 0;
  logic prev_we_n = 1'b1, prev_dq_oe = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      oe_run = 0;
      we_run = 0;
    end else begin
      if (sram_dq_oe && !sram_oe_n) chk("dq_oe_vs_oe_n", 32'd1, 32'd0);
      if (!sram_oe_n) oe_run++;
      else if (oe_run > 0) begin
        chk("oe_n_low_cycles", 32'(oe_run), 32'(RD_WAIT));
        oe_run = 0;
      end
      if (!sram_we_n) we_run++;
      else if (we_run > 0) begin
        chk("we_n_low_cycles", 32'(we_run), 32'(WR_WAIT));
        we_run = 0;
      end
      if (!prev_we_n && sram_we_n) we_rise = cyc;
      if (prev_dq_oe && !sram_dq_oe) chk("dq_oe_fall_after_we", 32'(cyc - we_rise), 32'd1);
    end
    prev_we_n  = sram_we_n;
    prev_dq_oe = sram_dq_oe;
  end

  // Drive one request; keep_valid leaves req_valid high for back-to-back use
  task automatic issue(input logic we, input logic [21:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, input logic [15:0] exp_rd,
                       input bit expect_rsp, input bit keep_valid);
    int wait_n = 0;
    int occ = 0;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    while (!req_ready && wait_n < 100) begin
      @(negedge clk);
      wait_n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    chk("setup_ce_n", 32'(sram_ce_n), 32'd0);
    chk("setup_ce2", 32'(sram_ce2), 32'd1);
    chk("setup_addr", 32'(sram_addr), 32'(addr));
    if (expect_rsp) begin
      e.data = exp_rd;
      e.at   = cyc + 1 + RD_WAIT;
      exp_q.push_back(e);
    end
    while (!req_ready && occ < 40) begin
      occ++;
      @(negedge clk);
    end
    chk(we ? "write_occupancy" : "read_occupancy", 32'(occ),
        32'(we ? WR_WAIT + 3 : RD_WAIT + 2));
  endtask

  logic exp_ce2_idle;
`ifdef SRAM_CTRL_CE2_PD_EN
  assign exp_ce2_idle = 1'b0;
`else
  assign exp_ce2_idle = 1'b1;
`endif

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_ctl"}, 32'({sram_ce_n, sram_ce2, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n, sram_dq_oe}),
        32'(7'b1011110));
    chk({tag, "_addr_dq"}, {sram_addr[15:0], sram_dq_o}, 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_valid, rsp_rdata, req_ready}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_pins("reset");
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    chk("ce2_idle", 32'(sram_ce2), 32'(exp_ce2_idle));

    issue(1'b0, 22'h000003, 16'h0000, 2'b11, 16'h1234, 1, 0);
    issue(1'b1, 22'h00000F, 16'hA5A5, 2'b11, 16'h0000, 0, 0);
    issue(1'b0, 22'h00000F, 16'h0000, 2'b11, 16'hA5A5, 1, 0);
    issue(1'b1, 22'h000010, 16'hBEEF, 2'b01, 16'h0000, 0, 0);
    issue(1'b0, 22'h000010, 16'h0000, 2'b11, 16'hFFEF, 1, 0);
    issue(1'b0, 22'h000010, 16'h0000, 2'b10, 16'hFF00, 1, 0);
    issue(1'b0, 22'h000003, 16'h0000, 2'b00, 16'h0000, 1, 0);
    issue(1'b1, 22'h000003, 16'hFFFF, 2'b00, 16'h0000, 0, 0);
    issue(1'b0, 22'h000003, 16'h0000, 2'b11, 16'h1234, 1, 0);
    chk("ce2_idle_after_ops", 32'(sram_ce2), 32'(exp_ce2_idle));

    // Back-to-back with req_valid held high throughout
    issue(1'b0, 22'h000003, 16'h0000, 2'b11, 16'h1234, 1, 1);
    issue(1'b1, 22'h000011, 16'h1111, 2'b11, 16'h0000, 0, 1);
    issue(1'b0, 22'h000011, 16'h0000, 2'b11, 16'h1111, 1, 0);

    // Reset during a read's ACCESS phase
    req_valid = 1'b1; req_we = 1'b0; req_addr = 22'h000005; req_be = 2'b11;
    for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_access", 32'(sram_oe_n), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_pins("abort");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", 32'(req_ready), 32'd1);
    repeat (8) @(negedge clk);
    chk("pending_rsp", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
